// File: rtl/vend_dispenser_if.sv
// Dispense back-end signal bundle: controller strobes and sensor in, actuator drives and status out.
// The slave modport is the dispenser's view; the master modport is the driving environment's view.
interface vend_dispenser_if #(
    parameter int QDEPTH = 4
);
    localparam int PW = $clog2(QDEPTH) + 1;

    logic          i_choco_out;
    logic          i_chng_out;
    logic          i_drop_sense;
    logic          o_motor_en;
    logic          o_coin_sol;
    logic          o_vend_done;
    logic          o_busy;
    logic [PW-1:0] o_pending;
    logic          o_ovf;
    logic          o_fault;

    modport slave (
        input  i_choco_out, i_chng_out, i_drop_sense,
        output o_motor_en, o_coin_sol, o_vend_done, o_busy, o_pending, o_ovf, o_fault
    );

    modport master (
        output i_choco_out, i_chng_out, i_drop_sense,
        input  o_motor_en, o_coin_sol, o_vend_done, o_busy, o_pending, o_ovf, o_fault
    );
endinterface

// File: rtl/vend_dispenser.sv
// Queues vend requests from the controller and sequences motor, drop confirmation and
// change solenoid for each one; a missing drop parks the block in a sticky fault state.
module vend_dispenser #(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 32,
    parameter int SOL_CYCLES   = 4,
    parameter int QDEPTH       = 4
) (
    input  logic            clk,
    input  logic            reset,
    vend_dispenser_if.slave bus
);
    localparam int AW   = $clog2(QDEPTH);
    localparam int PW   = AW + 1;
    localparam int MAX1 = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int MAXC = (MAX1 > SOL_CYCLES) ? MAX1 : SOL_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_WAIT_DROP,
        S_CHANGE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_drop_seen;
    logic           r_choco_d;
    logic           r_mem [QDEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [PW-1:0]  r_count;
    logic           r_motor_en;
    logic           r_coin_sol;
    logic           r_vend_done;
    logic           r_busy;
    logic           r_ovf;
    logic           r_fault;

    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_accept;
    logic           w_head;
    logic           w_seen;
    logic           w_last;
    logic           w_next_idle;
    logic [PW-1:0]  w_count_nxt;

    assign w_push      = bus.i_choco_out & ~r_choco_d;
    assign w_pop       = (r_state == S_DONE);
    assign w_full      = (r_count == PW'(QDEPTH));
    assign w_accept    = w_push & (~w_full | w_pop);
    assign w_head      = r_mem[r_rptr];
    assign w_seen      = r_drop_seen | bus.i_drop_sense;
    assign w_last      = (r_cnt == CW'(1));
    assign w_count_nxt = r_count + {{(PW-1){1'b0}}, w_accept} - {{(PW-1){1'b0}}, w_pop};
    // The FSM lands in IDLE next cycle only from DONE, or by staying in IDLE with nothing queued.
    assign w_next_idle = ((r_state == S_IDLE) && (r_count == '0)) || (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_choco_d <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_mem[i] <= 1'b0;
            end
        end else begin
            r_choco_d <= bus.i_choco_out;
            if (w_accept) begin
                r_mem[r_wptr] <= bus.i_chng_out;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Actuator outputs are updated together with the state so they track it cycle-exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_drop_seen <= 1'b0;
            r_motor_en  <= 1'b0;
            r_coin_sol  <= 1'b0;
            r_vend_done <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_vend_done <= 1'b0;
            r_busy      <= ~w_next_idle | (w_count_nxt != '0);
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= S_MOTOR;
                        r_cnt       <= CW'(MOTOR_CYCLES);
                        r_drop_seen <= 1'b0;
                        r_motor_en  <= 1'b1;
                    end
                end
                S_MOTOR: begin
                    if (bus.i_drop_sense) begin
                        r_drop_seen <= 1'b1;
                    end
                    if (w_last) begin
                        r_motor_en <= 1'b0;
                        if (!w_seen) begin
                            r_state <= S_WAIT_DROP;
                            r_cnt   <= CW'(DROP_TIMEOUT);
                        end else if (w_head) begin
                            r_state    <= S_CHANGE;
                            r_cnt      <= CW'(SOL_CYCLES);
                            r_coin_sol <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_cnt       <= '0;
                            r_vend_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WAIT_DROP: begin
                    if (bus.i_drop_sense) begin
                        if (w_head) begin
                            r_state    <= S_CHANGE;
                            r_cnt      <= CW'(SOL_CYCLES);
                            r_coin_sol <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_cnt       <= '0;
                            r_vend_done <= 1'b1;
                        end
                    end else if (w_last) begin
                        r_state <= S_FAULT;
                        r_cnt   <= '0;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_CHANGE: begin
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_cnt       <= '0;
                        r_coin_sol  <= 1'b0;
                        r_vend_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_motor_en  = r_motor_en;
    assign bus.o_coin_sol  = r_coin_sol;
    assign bus.o_vend_done = r_vend_done;
    assign bus.o_busy      = r_busy;
    assign bus.o_pending   = r_count;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_fault     = r_fault;
endmodule

// File: tb/tb_vend_dispenser.sv
// Randomised scoreboard bench for vend_dispenser: requests feed an expected-vend queue,
// a monitor checks each completed vend, and directed phases cover overflow, fault and reset.
module tb_vend_dispenser;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vend_dispenser_if #(.QDEPTH(QD)) bus();

    vend_dispenser #(
        .MOTOR_CYCLES(8),
        .DROP_TIMEOUT(32),
        .SOL_CYCLES(4),
        .QDEPTH(QD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int fails = 0;
    bit expQ[$];
    int modelPending = 0;
    bit modelOvf = 1'b0;
    bit prevChoco = 1'b0;
    int sensorMode = 0;
    int fixedDelay = 3;
    int curDelay = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // One cycle: check queue status, update the request model, then drive the next inputs.
    task automatic applyStimulus(input bit choco, input bit chng);
        bit pop;
        bit req;
        @(negedge clk);
        checkOutput("pending", int'(bus.o_pending), modelPending);
        checkOutput("busy", int'(bus.o_busy), int'(modelPending != 0));
        checkOutput("ovf", int'(bus.o_ovf), int'(modelOvf));
        pop = bus.o_vend_done;
        req = choco && !prevChoco;
        prevChoco = choco;
        if (req) begin
            if (modelPending < QD || pop) begin
                expQ.push_back(chng);
                modelPending++;
            end else begin
                modelOvf = 1'b1;
            end
        end
        if (pop) modelPending--;
        bus.i_choco_out = choco;
        bus.i_chng_out  = chng;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        bus.i_choco_out = 1'b0;
        bus.i_chng_out  = 1'b0;
        repeat (3) @(negedge clk);
        expQ.delete();
        modelPending = 0;
        modelOvf = 1'b0;
        prevChoco = 1'b0;
        reset = 1'b1;
        checkOutput("reset pending", int'(bus.o_pending), 0);
        checkOutput("reset motor", int'(bus.o_motor_en), 0);
        checkOutput("reset sol", int'(bus.o_coin_sol), 0);
        checkOutput("reset done", int'(bus.o_vend_done), 0);
        checkOutput("reset fault", int'(bus.o_fault), 0);
        checkOutput("reset ovf", int'(bus.o_ovf), 0);
        checkOutput("reset busy", int'(bus.o_busy), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (modelPending != 0 && n < 600) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        if (modelPending != 0) checkOutput("drain timeout", 1, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("scoreboard empty", expQ.size(), 0);
    endtask

    // Drop sensor: fires once, a chosen number of cycles after each motor start.
    int sIdx = -1;
    int sDelay = -5;
    bit sPrev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            sIdx = -1;
            sPrev = 1'b0;
            bus.i_drop_sense = 1'b0;
        end else begin
            if (bus.o_motor_en && !sPrev) begin
                sIdx = 0;
                sDelay = (sensorMode == 0) ? int'($urandom_range(0, 39)) : fixedDelay;
                curDelay = sDelay;
            end else if (sIdx >= 0 && sIdx < 100) begin
                sIdx++;
            end
            sPrev = bus.o_motor_en;
            bus.i_drop_sense = (sensorMode != 2) && (sIdx >= 0) && (sIdx == sDelay);
        end
    end

    // Monitor: each vend_done retires the oldest expected request.
    int mCyc = 0;
    int mMotor = 0;
    int mSol = 0;
    bit mActive = 1'b0;
    bit mPrev = 1'b0;
    always @(negedge clk) begin
        bit flag;
        int expLen;
        if (!reset) begin
            mActive = 1'b0;
            mPrev = 1'b0;
        end else begin
            if (bus.o_motor_en && !mPrev) begin
                mActive = 1'b1;
                mCyc = 0;
                mMotor = 0;
                mSol = 0;
            end else if (mActive) begin
                mCyc++;
            end
            mPrev = bus.o_motor_en;
            if (mActive) begin
                mMotor += int'(bus.o_motor_en);
                mSol += int'(bus.o_coin_sol);
            end
            if (bus.o_vend_done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected vend_done: actual 1 required 0");
                end else begin
                    flag = expQ.pop_front();
                    expLen = ((curDelay <= 7) ? 8 : curDelay + 1) + (flag ? 4 : 0);
                    checkOutput("vend length", mCyc, expLen);
                    checkOutput("motor cycles", mMotor, 8);
                    checkOutput("sol cycles", mSol, flag ? 4 : 0);
                end
                mActive = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        bit seen;
        bus.i_choco_out = 1'b0;
        bus.i_chng_out  = 1'b0;
        applyReset();

        // Single no-change vend, drop in motor cycle 3, with latency checks.
        sensorMode = 1;
        fixedDelay = 3;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("motor before start", int'(bus.o_motor_en), 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("motor at start", int'(bus.o_motor_en), 1);
        drain();

        // Change vend, drop five cycles into WAIT_DROP.
        fixedDelay = 12;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        drain();

        // Held level counts once; change-only pulse ignored.
        fixedDelay = 3;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("held queue", int'(bus.o_pending), 1);
        drain();

        // Five quick requests against a depth-4 queue.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("overflow pending", int'(bus.o_pending), 4);
        checkOutput("overflow flag", int'(bus.o_ovf), 1);
        drain();

        // Random traffic with random drop timing.
        applyReset();
        sensorMode = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end
        drain();

        // No drop: fault timing, frozen queue, reset recovery.
        applyReset();
        sensorMode = 2;
        applyStimulus(1'b1, 1'b0);
        k = 0;
        while (!bus.o_motor_en && k < 50) begin
            applyStimulus(1'b0, 1'b0);
            k++;
        end
        checkOutput("fault motor start", int'(bus.o_motor_en), 1);
        k = 0;
        seen = 1'b0;
        while (!bus.o_fault && k < 100) begin
            applyStimulus(1'b0, 1'b0);
            seen |= bus.o_coin_sol;
            k++;
        end
        checkOutput("fault latency", k, 40);
        checkOutput("fault sol", int'(seen), 0);
        applyStimulus(1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0);
            seen |= bus.o_motor_en | bus.o_coin_sol | bus.o_vend_done;
        end
        checkOutput("fault actuators", int'(seen), 0);
        checkOutput("fault sticky", int'(bus.o_fault), 1);
        applyReset();

        // Reset during CHANGE drops the solenoid without a clock edge.
        sensorMode = 1;
        fixedDelay = 2;
        applyStimulus(1'b1, 1'b1);
        k = 0;
        while (!bus.o_coin_sol && k < 60) begin
            applyStimulus(1'b0, 1'b0);
            k++;
        end
        checkOutput("change reached", int'(bus.o_coin_sol), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async sol drop", int'(bus.o_coin_sol), 0);
        checkOutput("async pending", int'(bus.o_pending), 0);
        applyReset();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0);
            seen |= bus.o_vend_done | bus.o_motor_en;
        end
        checkOutput("post-reset idle", int'(seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Physical dispense back-end for the vending machine controller. It consumes the controller's `choco_out`/`chng_out` strobes and queues each vend request. Each request then drives a product motor, confirms the drop with a sensor, and optionally fires the change-coin solenoid. Hardware timeouts flag a jammed product, and all actuator outputs are registered.

## Interface
- `MOTOR_CYCLES`, default 8: cycles `motor_en` is held per vend (≥1).
- `DROP_TIMEOUT`, default 32: maximum cycles waited for `drop_sense` after the motor phase (≥1).
- `SOL_CYCLES`, default 4: cycles `coin_sol` is held for a change payout (≥1).
- `QDEPTH`, default 4: request FIFO depth (power of 2, ≥2).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `choco_out`, in, 1: vend request level from the controller.
- `chng_out`, in, 1: change qualifier, valid in the same cycle as `choco_out`.
- `drop_sense`, in, 1: product-dropped sensor, active-high. It is synchronous to `clk`.
- `motor_en`, out, 1: product motor drive.
- `coin_sol`, out, 1: change solenoid drive.
- `vend_done`, out, 1: 1-cycle pulse when a request completes.
- `busy`, out, 1: high when the FSM is not in IDLE or the queue is non-empty.
- `pending`, out, clog2(QDEPTH)+1: number of queued requests, including the one in service.
- `ovf`, out, 1: sticky flag; a request was dropped because the queue was full.
- `fault`, out, 1: sticky flag; drop timeout occurred.

## Operation
- **Request capture**
  - A request is a rising edge of `choco_out`, detected against a registered copy of `choco_out`.
  - On that edge, one entry is pushed, carrying the value of `chng_out` in that cycle.
  - `chng_out` high with `choco_out` low is ignored.
  - A level held high for multiple cycles counts as one request.
- **FIFO**
  - Entries are 1 bit wide (the change flag), QDEPTH deep.
  - Head is removed only in DONE.
  - Push and pop in the same cycle: both occur; `pending` is unchanged.
  - Push while full with no pop in that cycle: the request is dropped and `ovf` is set.
  - Push while full coincident with a pop: the request is accepted.
- **FSM states**: IDLE, MOTOR, WAIT_DROP, CHANGE, DONE, FAULT.
  - IDLE → MOTOR when the FIFO is non-empty. The motor counter loads MOTOR_CYCLES and `drop_seen` clears.
  - MOTOR: `motor_en`=1. `drop_sense` high in any MOTOR cycle sets `drop_seen`.
    - After MOTOR_CYCLES cycles: if `drop_seen`, go to CHANGE when the head flag is 1, otherwise DONE.
    - If `drop_seen` is not set, go to WAIT_DROP.
  - WAIT_DROP: `motor_en`=0.
    - `drop_sense` high goes to CHANGE or DONE, chosen by the head flag.
    - After DROP_TIMEOUT cycles without `drop_sense`, go to FAULT.
  - CHANGE: `coin_sol`=1 for SOL_CYCLES cycles, then DONE.
  - DONE: `vend_done`=1 for one cycle; pop the head; return to IDLE.
  - FAULT: terminal until reset. `motor_en`, `coin_sol` and `vend_done` are 0 and `fault`=1.
    - The queue is frozen; further pushes still count into the FIFO if there is space and otherwise set `ovf`.
- **Counters**: one shared down-counter, wide enough for max(MOTOR_CYCLES, DROP_TIMEOUT, SOL_CYCLES). It is reloaded on every state entry.

## Timing
- **Reset** (async assert, sync deassert by the `clk` domain user):
  - All outputs are 0 and `pending`=0.
  - FIFO is empty, FSM is in IDLE, and the edge-detect register is 0.
  - Reset asserted mid-vend drops `motor_en` and `coin_sol` immediately, without waiting for a clock edge.
- **Latency**
  - A request sampled at edge t is pushed at t, so `pending` increments after t.
  - The FSM leaves IDLE at t+1, so `motor_en` is high from t+1 for exactly MOTOR_CYCLES cycles.
- **Vend length**
  - Minimum no-change vend (drop seen during MOTOR): MOTOR_CYCLES + 1 cycles from MOTOR entry to the end of the `vend_done` pulse.
  - With change, add SOL_CYCLES.
- **Back-to-back requests**: after DONE the FSM returns to IDLE for one cycle before the next MOTOR. The gap between successive `motor_en` windows is therefore ≥2 cycles.
- **Drop timing**: `drop_sense` arriving in the last cycle of DROP_TIMEOUT counts as a drop, not a fault.
- **Outputs**: all outputs are registered; none are combinational from inputs.

## Test plan
- Reset, then a single `choco_out` pulse with `chng_out`=0, and `drop_sense` at motor cycle 3:
  - `motor_en` is high for 8 cycles starting 1 cycle after the pulse.
  - `coin_sol` never rises.
  - `vend_done` pulses once; `pending` goes 1 → 0.
- A `choco_out`+`chng_out` pulse, with `drop_sense` 5 cycles after the motor phase ends:
  - WAIT_DROP is exited on the sense.
  - `coin_sol` is high for 4 cycles, then `vend_done` pulses.
- Five requests within 20 cycles while the first is in service (QDEPTH=4):
  - `pending` saturates at 4 and `ovf`=1.
  - Exactly four `vend_done` pulses occur, with change flags serviced in arrival order.
- No `drop_sense` after a request:
  - `fault` rises exactly 8+32 cycles after MOTOR entry.
  - Motor and solenoid stay 0; later requests are not serviced.
  - Asserting `reset` (low) clears `fault`.
- `reset` asserted low during CHANGE:
  - `coin_sol` drops asynchronously.
  - After release: `pending`=0, the FSM is in IDLE, and no `vend_done` occurs.
- `choco_out` held high for 3 cycles, plus a `chng_out`-only pulse:
  - Exactly one request is queued.
  - The `chng_out`-only pulse is ignored.
